// File: rtl/seq_mul_unit.sv
// seq_mul_unit: sequential shift-add multiplier with valid/ready handshakes.
// Define SEQ_MUL_UNIT_ACC_EN to add the acc_clr/acc_out product accumulator.
module seq_mul_unit #(
  parameter int WIDTH = 6,
  parameter int SIGNED = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] mul_out,
  output logic               busy
`ifdef SEQ_MUL_UNIT_ACC_EN
  ,
  input  logic               acc_clr,
  output logic [2*WIDTH+7:0] acc_out
`endif
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [PW-1:0] ma, p, sum;
  logic [WIDTH-1:0] mb, xm, ym;
  logic neg, sx, sy, last, accept;
  // Operands are stored as magnitudes; the sign is reapplied once at the end.
  always_comb begin
    sx = (SIGNED != 0) && x[WIDTH-1];
    sy = (SIGNED != 0) && y[WIDTH-1];
    xm = sx ? -x : x;
    ym = sy ? -y : y;
    sum = p + (mb[0] ? ma : '0);
    last = cnt == CW'(WIDTH - 1);
    in_ready = state == IDLE;
    busy = state == BUSY;
    out_valid = state == DONE;
    accept = in_valid && in_ready;
    state_nx = accept ? BUSY :
               (busy && last) ? DONE :
               (out_valid && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      ma <= '0;
      mb <= '0;
      p <= '0;
      neg <= 1'b0;
      mul_out <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        ma <= {{WIDTH{1'b0}}, xm};
        mb <= ym;
        neg <= sx ^ sy;
        p <= '0;
        cnt <= '0;
      end else if (busy) begin
        p <= sum;
        ma <= ma << 1;
        mb <= mb >> 1;
        cnt <= cnt + 1'b1;
        if (last) mul_out <= neg ? -sum : sum;
      end
    end
  end
`ifdef SEQ_MUL_UNIT_ACC_EN
  logic [PW+7:0] ext;
  assign ext = (SIGNED != 0) ? {{8{mul_out[PW-1]}}, mul_out} : {8'd0, mul_out};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_out <= '0;
    else acc_out <= acc_clr ? '0 : (out_valid && out_ready) ? acc_out + ext : acc_out;
  end
`endif
endmodule

// File: tb/tb_seq_mul_unit.sv
// tb_seq_mul_unit: scoreboard bench driving an unsigned and a signed instance in lockstep.
module tb_seq_mul_unit;
  localparam int W = 6;
  logic clk = 0, rst = 0, in_valid = 0, out_ready = 1;
  logic [W-1:0] x = 0, y = 0;
  logic in_ready0, out_valid0, busy0, in_ready1, out_valid1, busy1;
  logic [2*W-1:0] mo0, mo1, eu, es;
  logic [2*W-1:0] qu[$], qs[$];
  int nvec = 0, nerr = 0;
`ifdef SEQ_MUL_UNIT_ACC_EN
  logic acc_clr = 0;
  logic [2*W+7:0] acc0, acc1, ea;
`endif

  always #5 clk = ~clk;

  seq_mul_unit #(.WIDTH(W), .SIGNED(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .x(x), .y(y),
    .out_valid(out_valid0), .out_ready(out_ready), .mul_out(mo0), .busy(busy0)
`ifdef SEQ_MUL_UNIT_ACC_EN
    , .acc_clr(acc_clr), .acc_out(acc0)
`endif
  );
  seq_mul_unit #(.WIDTH(W), .SIGNED(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .x(x), .y(y),
    .out_valid(out_valid1), .out_ready(out_ready), .mul_out(mo1), .busy(busy1)
`ifdef SEQ_MUL_UNIT_ACC_EN
    , .acc_clr(acc_clr), .acc_out(acc1)
`endif
  );

  function automatic logic [2*W-1:0] mu(input logic [W-1:0] a, input logic [W-1:0] b);
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  function automatic logic [2*W-1:0] ms(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sa, sb;
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    return sa * sb;
  endfunction

  // Drives one pair from IDLE, records the expected products, and returns the
  // number of edges (accept edge counted as 1) until out_valid is seen.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    x = a;
    y = b;
    in_valid = 1;
    qu.push_back(mu(a, b));
    qs.push_back(ms(a, b));
    @(posedge clk); #1;
    in_valid = 0;
    x = W'($urandom_range(0, 63));
    y = W'($urandom_range(0, 63));
    lat = 1;
    while (out_valid0 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    #2 rst = 1;
    #1;
    nvec++;
    if ({in_ready0, out_valid0, busy0, in_ready1, out_valid1, busy1} !== 6'b100100 || mo0 !== 0 || mo1 !== 0) begin
      nerr++;
      $display("FAIL reset: flags=%b mo0=%0d mo1=%0d, required flags=100100 products 0",
               {in_ready0, out_valid0, busy0, in_ready1, out_valid1, busy1}, mo0, mo1);
    end
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_unsigned_max();
    int lat;
    issue(6'd63, 6'd63, lat);
    nvec++;
    if (lat !== 7 || out_valid1 !== 1'b1) begin
      nerr++;
      $display("FAIL max_latency: got %0d edges (u1 valid=%b), required 7", lat, out_valid1);
    end
    eu = qu.pop_front();
    es = qs.pop_front();
    nvec++;
    if (mo0 !== eu || mo1 !== es || eu !== 12'd3969) begin
      nerr++;
      $display("FAIL max_product: got %0d/%0d, required %0d/%0d (3969 unsigned)", mo0, mo1, eu, es);
    end
    @(posedge clk); #1;
    nvec++;
    if ({in_ready0, out_valid0, in_ready1, out_valid1} !== 4'b1010) begin
      nerr++;
      $display("FAIL max_idle: flags=%b, required 1010", {in_ready0, out_valid0, in_ready1, out_valid1});
    end
  endtask

  task automatic test_signed();
    logic [W-1:0] av[4] = '{6'h20, 6'h3F, 6'h00, 6'h1F};
    logic [W-1:0] bv[4] = '{6'h20, 6'h1F, 6'h3B, 6'h20};
    int lat;
    for (int k = 0; k < 4; k++) begin
      issue(av[k], bv[k], lat);
      nvec++;
      if (lat !== 7) begin
        nerr++;
        $display("FAIL signed_latency[%0d]: got %0d edges, required 7", k, lat);
      end
      eu = qu.pop_front();
      es = qs.pop_front();
      nvec++;
      if (mo0 !== eu || mo1 !== es) begin
        nerr++;
        $display("FAIL signed_product[%0d]: got u=%h s=%h, required u=%h s=%h", k, mo0, mo1, eu, es);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    int lat;
    for (int k = 0; k < 6; k++) begin
      issue(W'($urandom_range(0, 63)), W'($urandom_range(0, 63)), lat);
      eu = qu.pop_front();
      es = qs.pop_front();
      nvec++;
      if (lat !== 7 || mo0 !== eu || mo1 !== es) begin
        nerr++;
        $display("FAIL random[%0d]: lat=%0d u=%h s=%h, required lat=7 u=%h s=%h", k, lat, mo0, mo1, eu, es);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 0;
    issue(6'd5, 6'd7, lat);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1;
      x = 6'd1;
      y = 6'd1;
      @(posedge clk); #1;
      nvec++;
      if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0 || mo0 !== 12'd35 || out_valid1 !== 1'b1 || mo1 !== 12'd35) begin
        nerr++;
        $display("FAIL hold[%0d]: valid=%b ready=%b mo0=%0d mo1=%0d, required valid=1 ready=0 35",
                 i, out_valid0, in_ready0, mo0, mo1);
      end
    end
    in_valid = 0;
    out_ready = 1;
    eu = qu.pop_front();
    es = qs.pop_front();
    nvec++;
    if (mo0 !== eu || mo1 !== es) begin
      nerr++;
      $display("FAIL bp_product: got %0d/%0d, required %0d/%0d", mo0, mo1, eu, es);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) begin
      nvec++;
      if (out_valid0 !== 1'b0 || busy0 !== 1'b0) begin
        nerr++;
        $display("FAIL bp_ignored[%0d]: valid=%b busy=%b, required 0 0", i, out_valid0, busy0);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    x = 6'd9;
    y = 6'd9;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1;
    #1;
    nvec++;
    if ({in_ready0, out_valid0, busy0, in_ready1, out_valid1, busy1} !== 6'b100100 || mo0 !== 0 || mo1 !== 0) begin
      nerr++;
      $display("FAIL midreset: flags=%b mo0=%0d mo1=%0d, required 100100 and 0",
               {in_ready0, out_valid0, busy0, in_ready1, out_valid1, busy1}, mo0, mo1);
    end
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      nvec++;
      if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
        nerr++;
        $display("FAIL stale_valid[%0d]: got %b%b, required 00", i, out_valid0, out_valid1);
      end
    end
    issue(6'd2, 6'd3, lat);
    eu = qu.pop_front();
    es = qs.pop_front();
    nvec++;
    if (lat !== 7 || mo0 !== eu || mo1 !== es) begin
      nerr++;
      $display("FAIL post_reset: lat=%0d got %0d/%0d, required lat=7 %0d/%0d", lat, mo0, mo1, eu, es);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] av[4] = '{6'd11, 6'd42, 6'd63, 6'd7};
    logic [W-1:0] bv[4] = '{6'd13, 6'd5, 6'd1, 6'd60};
    logic [2:0] want;
    out_ready = 1;
    in_valid = 1;
    for (int k = 0; k < 4; k++) begin
      x = av[k];
      y = bv[k];
      qu.push_back(mu(av[k], bv[k]));
      qs.push_back(ms(av[k], bv[k]));
      for (int i = 1; i <= 8; i++) begin
        @(posedge clk); #1;
        if (i == 1) begin
          x = W'($urandom_range(0, 63));
          y = W'($urandom_range(0, 63));
        end
        if (i == 8 && k == 3) in_valid = 0;
        want = (i <= 6) ? 3'b100 : (i == 7) ? 3'b010 : 3'b001;
        nvec++;
        if ({busy0, out_valid0, in_ready0} !== want || {busy1, out_valid1, in_ready1} !== want) begin
          nerr++;
          $display("FAIL b2b_flags[%0d.%0d]: got %b/%b, required %b", k, i,
                   {busy0, out_valid0, in_ready0}, {busy1, out_valid1, in_ready1}, want);
        end
        if (i == 7) begin
          eu = qu.pop_front();
          es = qs.pop_front();
          nvec++;
          if (mo0 !== eu || mo1 !== es) begin
            nerr++;
            $display("FAIL b2b_product[%0d]: got %0d/%h, required %0d/%h", k, mo0, mo1, eu, es);
          end
        end
      end
    end
  endtask

`ifdef SEQ_MUL_UNIT_ACC_EN
  task automatic test_acc();
    logic [W-1:0] av[4] = '{6'd10, 6'd20, 6'd0, 6'd3};
    int lat;
    acc_clr = 1;
    @(posedge clk); #1;
    acc_clr = 0;
    ea = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        acc_clr = 1;
        @(posedge clk); #1;
        acc_clr = 0;
        ea = 0;
      end else begin
        issue(av[k], av[k], lat);
        eu = qu.pop_front();
        es = qs.pop_front();
        ea = ea + {8'd0, eu};
        @(posedge clk); #1;
      end
      nvec++;
      if (acc0 !== ea || acc1 !== ea) begin
        nerr++;
        $display("FAIL acc[%0d]: got %0d/%0d, required %0d", k, acc0, acc1, ea);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed();
    test_random();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
`ifdef SEQ_MUL_UNIT_ACC_EN
    test_acc();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
